fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the IF stage of the 5-stage RV32I pipeline.
- Owns the fetch PC and issues requests to a variable-latency instruction memory, with one request outstanding at most.
- Loads the IF/ID pipeline register, honours decode stalls, and applies EX-stage branch/jump redirects.
- Stale responses are dropped after a redirect. A one-entry skid buffer absorbs a response that returns while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC value after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_d when the slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- stall_d  in  1  decode cannot accept a new instruction this cycle
- pcsrc_e  in  1  EX-stage redirect (taken branch or jump)
- pc_target_e  in  32  redirect target; bits [1:0] are forced to 0
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID slot holds a real instruction
- drop_cnt  out  16  count of killed responses; saturates at 16'hFFFF

Behaviour:
- Reset, asynchronous, while rst=1:
  - pc_f=RESET_PC, state=REQ, kill=0, skid empty.
  - valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, drop_cnt=0.
  - imem_req=0 while rst is high.
- States and transitions:
  - REQ: imem_req=1, imem_addr=pc_f. On imem_ready, go to WAIT.
  - WAIT: waiting on the outstanding response. Ignore imem_rvalid in every other state.
  - HOLD: skid buffer is full. imem_req=0.
- Accept condition: IF/ID can accept when (!valid_d || !stall_d).
- WAIT, imem_rvalid=1, kill=0, IF/ID can accept:
  - Load IF/ID with {imem_rdata, pc_f, pc_f+4} and set valid_d=1.
  - Set pc_f to pc_f+4.
  - In the same cycle, imem_req=1 with imem_addr=pc_f+4 (combinational, back-to-back issue). With imem_ready=1, stay in WAIT; otherwise go to REQ.
  - Result: 1 instruction per cycle with single-cycle memory.
- WAIT, imem_rvalid=1, kill=0, IF/ID cannot accept:
  - Store {rdata, pc_f} in the skid buffer, set pc_f to pc_f+4, go to HOLD.
- HOLD, stall_d=0: move the skid contents into IF/ID (valid_d=1), go to REQ.
- WAIT, imem_rvalid=1, kill=1:
  - Discard the data, clear kill, increment drop_cnt.
  - In the same cycle, imem_req=1 at pc_f (already the target). Go to WAIT if imem_ready, else REQ.
- Stall with no arriving data: when stall_d=1 and valid_d=1, IF/ID holds its value.
- When decode consumes the slot (stall_d=0) and no new data arrives, valid_d drops to 0 and instr_d returns to NOP_INSTR.
- Redirect (pcsrc_e=1) has top priority, over stall and over a same-cycle response:
  - pc_f is set to {pc_target_e[31:2],2'b00}.
  - valid_d is set to 0 and instr_d to NOP_INSTR (flush).
  - The skid buffer is emptied.
  - In HOLD: go to REQ.
  - In REQ with imem_ready=1 in the same cycle: the request already went out at the old PC. Go to WAIT with kill=1.
  - In REQ without imem_ready: the address changes next cycle; a pending unaccepted request may change its address.
  - In WAIT without rvalid: set kill=1.
  - In WAIT with rvalid in the same cycle: drop the response (drop_cnt+1) and go to REQ. No same-cycle reissue.
- Back-to-back redirects: the last one wins. kill stays a single bit because only one request can be outstanding.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-transaction: all state clears immediately. Any response arriving after reset release while in REQ is ignored.

Decomposition:
- Shared package (pipeline_pkg): state encoding (FS_REQ, FS_WAIT, FS_HOLD), NOP_INSTR, RESET_PC default, XLEN=32.
- One sub-module is natural: fetch_skid_buf, a 1-entry {instr, pc} register with load/unload/clear.
- The PC+4 adder stays inline.

Test Plan:
- Reset, then single-cycle memory (ready=1, rvalid one cycle after accept, rdata=addr|0x1000): imem_addr sequence 0,4,8,C on consecutive cycles. From the first response onward, pc_d follows 0,4,8 at 1/cycle with valid_d=1 throughout.
- Hold stall_d=1 for 3 cycles while valid_d=1: IF/ID unchanged and one response is captured in the skid (state HOLD, imem_req=0). After release, the skid value appears in IF/ID next cycle and fetch resumes at the following PC.
- pcsrc_e=1, pc_target_e=0x0000_0102, while WAIT with a 3-cycle memory latency: valid_d goes to 0 next cycle. The stale response is dropped (drop_cnt=1). The next imem_addr is 0x100, and pc_d=0x100 follows.
- pcsrc_e=1 in the same cycle as imem_rvalid, with decode stalled: the response is dropped, the flush overrides the stall (valid_d=0), and the next request goes to the target.
- RESET_PC=32'hFFFF_FFF8, single-cycle memory: request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, with pc_plus4_d wrapping to 0.
- Assert rst for 1 cycle while WAIT: outputs return to reset values asynchronously. The late rvalid is ignored and the first post-reset request is at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared IF-stage definitions: fetch FSM encoding, reset/NOP defaults and the skid payload.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = '0;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam logic [1:0] FS_REQ  = 2'd0;
    localparam logic [1:0] FS_WAIT = 2'd1;
    localparam logic [1:0] FS_HOLD = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_skid_buf.sv
// One-entry {instr, pc} holding register for a response that arrives while decode is stalled.
module fetch_skid_buf
    import pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       clear_i,
    input  fetch_pkt_t pkt_i,
    output logic       full_o,
    output fetch_pkt_t pkt_o
);

    logic       full_q;
    fetch_pkt_t pkt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            pkt_q  <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            pkt_q  <= pkt_i;
        end
    end

    assign full_o = full_q;
    assign pkt_o  = pkt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the fetch PC, keeps one imem request in flight and loads IF/ID.
module fetch_sequencer
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic [15:0]     drop_cnt
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic            kill_q, kill_d;
    logic            idv_q, idv_d;
    logic [XLEN-1:0] idi_q, idi_d;
    logic [XLEN-1:0] idpc_q, idpc_d;
    logic [XLEN-1:0] idpc4_q, idpc4_d;
    logic [15:0]     drop_q, drop_d;

    logic            req_c;
    logic [XLEN-1:0] addr_c;
    logic            drop_inc;
    logic            skid_load, skid_clear, skid_full;
    fetch_pkt_t      skid_pkt;
    logic [XLEN-1:0] fpc_plus4;
    logic            accept;

    assign fpc_plus4 = fpc_q + 32'd4;
    assign accept    = !idv_q || !stall_d;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pkt_i   ('{instr: imem_rdata, pc: fpc_q}),
        .full_o  (skid_full),
        .pkt_o   (skid_pkt)
    );

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        kill_d     = kill_q;
        idv_d      = idv_q;
        idi_d      = idi_q;
        idpc_d     = idpc_q;
        idpc4_d    = idpc4_q;
        drop_d     = drop_q;
        req_c      = 1'b0;
        addr_c     = fpc_q;
        drop_inc   = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        // Slot consumed (or empty) with nothing new arriving reverts to a bubble.
        if (accept) begin
            idv_d = 1'b0;
            idi_d = NOP_INSTR;
        end

        if (pcsrc_e) begin
            fpc_d      = word_align(pc_target_e);
            idv_d      = 1'b0;
            idi_d      = NOP_INSTR;
            skid_clear = 1'b1;
            case (state_q)
                FS_REQ: begin
                    req_c = 1'b1;
                    if (imem_ready) begin
                        state_d = FS_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        drop_inc = 1'b1;
                        kill_d   = 1'b0;
                        state_d  = FS_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: state_d = FS_REQ;
            endcase
        end else begin
            case (state_q)
                FS_REQ: begin
                    req_c = 1'b1;
                    if (imem_ready) state_d = FS_WAIT;
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d   = 1'b0;
                            drop_inc = 1'b1;
                            req_c    = 1'b1;
                            state_d  = imem_ready ? FS_WAIT : FS_REQ;
                        end else if (accept) begin
                            idv_d   = 1'b1;
                            idi_d   = imem_rdata;
                            idpc_d  = fpc_q;
                            idpc4_d = fpc_plus4;
                            fpc_d   = fpc_plus4;
                            req_c   = 1'b1;
                            addr_c  = fpc_plus4;
                            state_d = imem_ready ? FS_WAIT : FS_REQ;
                        end else begin
                            skid_load = 1'b1;
                            fpc_d     = fpc_plus4;
                            state_d   = FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall_d && skid_full) begin
                        idv_d      = 1'b1;
                        idi_d      = skid_pkt.instr;
                        idpc_d     = skid_pkt.pc;
                        idpc4_d    = skid_pkt.pc + 32'd4;
                        skid_clear = 1'b1;
                        state_d    = FS_REQ;
                    end
                end
                default: state_d = FS_REQ;
            endcase
        end

        if (drop_inc && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_REQ;
            fpc_q   <= RESET_PC;
            kill_q  <= 1'b0;
            idv_q   <= 1'b0;
            idi_q   <= NOP_INSTR;
            idpc_q  <= '0;
            idpc4_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            kill_q  <= kill_d;
            idv_q   <= idv_d;
            idi_q   <= idi_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
            drop_q  <= drop_d;
        end
    end

    assign imem_req   = req_c && !rst;
    assign imem_addr  = addr_c;
    assign instr_d    = idi_q;
    assign pc_d       = idpc_q;
    assign pc_plus4_d = idpc4_q;
    assign valid_d    = idv_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle vector table, IF/ID scoreboard, corner-case sequences.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_d = 1'b0;
    logic        pcsrc_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instr_d, instr_d2, pc_d, pc_d2, pc_plus4_d, pc_plus4_d2;
    logic        valid_d, valid_d2;
    logic [15:0] drop_cnt, drop_cnt2;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .pcsrc_e(pcsrc_e), .pc_target_e(pc_target_e),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .drop_cnt(drop_cnt)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall_d(stall_d), .pcsrc_e(pcsrc_e), .pc_target_e(pc_target_e),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_d(instr_d2), .pc_d(pc_d2),
        .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // IF/ID scoreboard: expected fetch PCs in delivery order.
    logic [31:0] exp_q[$];
    logic        prev_valid = 1'b0;

    task automatic sb_check(input logic stall_at_edge);
        logic [31:0] e;
        if (valid_d && (!prev_valid || !stall_at_edge)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no delivery", pc_d);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc_d, e);
                chk("sb_instr", instr_d, e | 32'h1000);
                chk("sb_pc4", pc_plus4_d, e + 32'd4);
            end
        end
        prev_valid = valid_d;
    endtask

    // Memory model: response lat cycles after acceptance, rdata = addr | 0x1000.
    int          lat = 1;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        s_req, s_req2;
    logic [31:0] s_addr, s_addr2;

    task automatic step();
        logic acc, stall_s;
        #2;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_req2  = imem_req2;
        s_addr2 = imem_addr2;
        acc     = imem_req && imem_ready;
        stall_s = stall_d;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            cnt       = lat;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr | 32'h1000;
                pend        = 1'b0;
            end
        end
        sb_check(stall_s);
    endtask

    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        chk_pc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 1'b1, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 1'b1, 32'h04};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 1'b1, 32'h08};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0C};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h10};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 1'b1, 32'h14};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 1'b1, 32'h14};

        #1 rst = 1'b1;
        #2;
        chk1("rst_valid", valid_d, 1'b0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_pc4", pc_plus4_d, 32'h0);
        chk("rst_drop", {16'h0, drop_cnt}, 32'h0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_req_w", imem_req2, 1'b0);
        chk("rst_instr_w", instr_d2, NOP);
        chk("rst_drop_w", {16'h0, drop_cnt2}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Streaming, 3-cycle stall into the skid, resume; wrap instance runs 8 bytes below.
        exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        for (int i = 0; i < 12; i++) begin
            stall_d    = tbl[i].stall;
            imem_ready = tbl[i].ready;
            step();
            chk1($sformatf("req[%0d]", i), s_req, tbl[i].exp_req);
            chk1($sformatf("req_w[%0d]", i), s_req2, tbl[i].exp_req);
            if (tbl[i].exp_req) begin
                chk($sformatf("addr[%0d]", i), s_addr, tbl[i].exp_addr);
                chk($sformatf("addr_w[%0d]", i), s_addr2, tbl[i].exp_addr + 32'hFFFF_FFF8);
            end
            chk1($sformatf("valid[%0d]", i), valid_d, tbl[i].exp_valid);
            chk1($sformatf("valid_w[%0d]", i), valid_d2, tbl[i].exp_valid);
            if (tbl[i].chk_pc) begin
                chk($sformatf("pc_d[%0d]", i), pc_d, tbl[i].exp_pc);
                chk($sformatf("pc_d_w[%0d]", i), pc_d2, tbl[i].exp_pc + 32'hFFFF_FFF8);
                chk($sformatf("pc4_w[%0d]", i), pc_plus4_d2, tbl[i].exp_pc + 32'hFFFF_FFFC);
            end
        end

        // Redirect while WAIT on a 3-cycle memory, decode stalled on a valid slot.
        lat = 3;
        imem_ready = 1'b1;
        step();
        chk1("r0_req", s_req, 1'b1);
        chk("r0_addr", s_addr, 32'h18);
        chk1("r0_valid", valid_d, 1'b1);
        pcsrc_e = 1'b1;
        pc_target_e = 32'h0000_0102;
        step();
        chk1("r1_req", s_req, 1'b0);
        chk1("r1_flush", valid_d, 1'b0);
        chk("r1_instr", instr_d, NOP);
        pcsrc_e = 1'b0;
        stall_d = 1'b0;
        step();
        chk1("r2_req", s_req, 1'b0);
        step();
        chk1("r3_req", s_req, 1'b1);
        chk("r3_addr", s_addr, 32'h100);
        chk("r3_drop", {16'h0, drop_cnt}, 32'd1);
        chk1("r3_valid", valid_d, 1'b0);
        step();
        step();
        exp_q.push_back(32'h100);
        step();
        chk1("r6_req", s_req, 1'b1);
        chk("r6_addr", s_addr, 32'h104);
        chk("r6_pc_d", pc_d, 32'h100);

        // Redirect coinciding with a response while decode is stalled.
        stall_d = 1'b1;
        step();
        step();
        pcsrc_e = 1'b1;
        pc_target_e = 32'h0000_0200;
        step();
        chk1("r9_req", s_req, 1'b0);
        chk1("r9_flush", valid_d, 1'b0);
        chk("r9_drop", {16'h0, drop_cnt}, 32'd2);
        pcsrc_e = 1'b0;
        stall_d = 1'b0;
        lat = 1;
        step();
        chk1("r10_req", s_req, 1'b1);
        chk("r10_addr", s_addr, 32'h200);
        exp_q.push_back(32'h200);
        step();
        chk("r11_addr", s_addr, 32'h204);
        chk1("r11_valid", valid_d, 1'b1);

        // Asynchronous reset while a response is due.
        #2 rst = 1'b1;
        #1;
        chk1("ar_valid", valid_d, 1'b0);
        chk("ar_instr", instr_d, NOP);
        chk("ar_pc_d", pc_d, 32'h0);
        chk("ar_pc4", pc_plus4_d, 32'h0);
        chk("ar_drop", {16'h0, drop_cnt}, 32'h0);
        chk1("ar_req", imem_req, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        pend = 1'b0;
        prev_valid = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        imem_ready = 1'b0;
        step();
        chk1("pr_req", s_req, 1'b1);
        chk("pr_addr", s_addr, 32'h0);
        chk1("pr_valid", valid_d, 1'b0);
        chk("pr_drop", {16'h0, drop_cnt}, 32'h0);
        imem_ready = 1'b1;
        step();
        chk("pr_addr2", s_addr, 32'h0);
        exp_q.push_back(32'h0);
        step();
        chk("pr_addr3", s_addr, 32'h4);
        chk1("pr_valid3", valid_d, 1'b1);

        chk("sb_left", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
